// File: rtl/mcs4_rom_loader.sv
// mcs4_rom_loader: streams bytes from an AXI-Stream-style source into the shared
// i4001 debug write port and holds the CPU in reset while ROM images change.
// Optional feature: define MCS4_LOADER_CSUM_EN to enable the mod-256 byte checksum
// on csum; otherwise csum is tied to zero.
//
// state | meaning
// IDLE  | CPU running, waiting for start; bad requests pulse err
// LOAD  | accepting stream bytes, one debug write per transfer
// HOLD  | CPU held in reset for CPU_HOLD_CYCLES before release
module mcs4_rom_loader #(
  parameter int NUM_ROMS        = 16,
  parameter int CPU_HOLD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] base_addr,
  input  logic [12:0] length,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [11:0] dbg_addr,
  output logic [7:0]  dbg_wdata,
  output logic        dbg_wen,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  csum
);

  localparam int HW = (CPU_HOLD_CYCLES > 1) ? $clog2(CPU_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(CPU_HOLD_CYCLES - 1);
  localparam logic [13:0]   ROM_LIMIT = 14'(NUM_ROMS * 256);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

  state_t        state, state_nx;
  logic [HW-1:0] hold_cnt, hold_cnt_nx;
  logic [11:0]   addr, addr_nx;
  logic [12:0]   remaining, remaining_nx;
  logic          loaded, loaded_nx;
  logic          done_nx, err_nx;
  logic          xfer, start_ok, start_accept;
  logic [13:0]   end_addr;

  // Range check is done 14 bits wide so base+length can never wrap into range.
  assign end_addr     = {2'b00, base_addr} + {1'b0, length};
  assign start_ok     = (length != 13'd0) && (length <= 13'd4096) && (end_addr <= ROM_LIMIT);
  assign start_accept = (state == S_IDLE) && start && start_ok;
  assign s_ready      = (state == S_LOAD) && (remaining != 13'd0);
  assign xfer         = s_valid && s_ready;
  assign busy         = (state != S_IDLE);

  // Next-state and datapath update decisions.
  always_comb begin
    state_nx     = state;
    hold_cnt_nx  = hold_cnt;
    addr_nx      = addr;
    remaining_nx = remaining;
    loaded_nx    = loaded;
    done_nx      = 1'b0;
    err_nx       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            addr_nx      = base_addr;
            remaining_nx = length;
            loaded_nx    = 1'b1;
            state_nx     = S_LOAD;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          addr_nx      = addr + 12'd1;
          remaining_nx = remaining - 13'd1;
          if (remaining == 13'd1) begin
            state_nx    = S_HOLD;
            hold_cnt_nx = HOLD_INIT;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt == '0) begin
          state_nx  = S_IDLE;
          done_nx   = loaded;
          loaded_nx = 1'b0;
        end else begin
          hold_cnt_nx = hold_cnt - 1'b1;
        end
      end
      default: state_nx = S_HOLD;
    endcase
  end

  // State, counters and registered outputs; reset parks the loader in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HOLD;
      hold_cnt  <= HOLD_INIT;
      addr      <= 12'd0;
      remaining <= 13'd0;
      loaded    <= 1'b0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      dbg_wen   <= 1'b0;
      dbg_addr  <= 12'd0;
      dbg_wdata <= 8'd0;
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_cnt_nx;
      addr      <= addr_nx;
      remaining <= remaining_nx;
      loaded    <= loaded_nx;
      cpu_rst   <= (state_nx != S_IDLE);
      done      <= done_nx;
      err       <= err_nx;
      dbg_wen   <= xfer;
      if (xfer) begin
        dbg_addr  <= addr;
        dbg_wdata <= s_data;
      end
    end
  end

`ifdef MCS4_LOADER_CSUM_EN
  logic [7:0] csum_q;

  // Checksum of the bytes written by the current or most recent load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            csum_q <= 8'd0;
    else if (start_accept) csum_q <= 8'd0;
    else if (xfer)         csum_q <= csum_q + s_data;
  end

  assign csum = csum_q;
`else
  logic unused_accept;
  assign unused_accept = start_accept;
  assign csum = 8'h00;
`endif

endmodule

// File: tb/tb_mcs4_rom_loader.sv
// Directed bench for mcs4_rom_loader with a write scoreboard (NUM_ROMS=2).
module tb_mcs4_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, s_valid, s_ready;
  logic [11:0] base_addr, dbg_addr;
  logic [12:0] length;
  logic [7:0]  s_data, dbg_wdata, csum;
  logic        dbg_wen, cpu_rst, busy, done, err;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          n_wen    = 0;
  logic [11:0] exp_addr = 12'd0;
  logic [7:0]  exp_csum = 8'd0;
  logic [19:0] sb_q[$];

  mcs4_rom_loader #(.NUM_ROMS(2), .CPU_HOLD_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_wen(dbg_wen), .cpu_rst(cpu_rst), .busy(busy),
    .done(done), .err(err), .csum(csum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] csum_exp(input logic [7:0] s);
`ifdef MCS4_LOADER_CSUM_EN
    return s;
`else
    return 8'h00 & s;
`endif
  endfunction

  // Scoreboard: pop on each strobe, push on each stream transfer.
  always @(negedge clk) begin
    logic [19:0] e;
    if (rst_n && dbg_wen) begin
      n_wen++;
      if (sb_q.size() == 0) check("extra_strobe", 32'(dbg_wen), 32'd0);
      else begin
        e = sb_q.pop_front();
        check("wr_addr", 32'(dbg_addr), 32'(e[19:8]));
        check("wr_data", 32'(dbg_wdata), 32'(e[7:0]));
      end
    end
    if (rst_n && s_valid && s_ready) begin
      sb_q.push_back({exp_addr, s_data});
      exp_addr = exp_addr + 12'd1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [11:0] b, input logic [12:0] l);
    tick();
    start = 1'b1; base_addr = b; length = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    s_valid = 1'b0;
    repeat (gap) tick();
    s_data = b; s_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!s_ready && k < 50) begin @(negedge clk); k++; end
    if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    exp_csum = exp_csum + b;
  endtask

  task automatic wait_done(input string tag);
    int k;
    @(negedge clk);
    check({tag, "_last_wen"}, 32'(dbg_wen), 32'd1);
    check({tag, "_hold_cpu_rst"}, 32'(cpu_rst), 32'd1);
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 30);
    check({tag, "_done_latency"}, 32'(k), 32'd8);
    check({tag, "_cpu_rst_off"}, 32'(cpu_rst), 32'd0);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_csum"}, 32'(csum), 32'(csum_exp(exp_csum)));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_release();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rel_cpu_rst_hi", 32'(cpu_rst), 32'd1);
      check("rel_done_lo", 32'(done), 32'd0);
    end
    @(negedge clk);
    check("rel_cpu_rst_lo", 32'(cpu_rst), 32'd0);
    check("rel_busy_lo", 32'(busy), 32'd0);
    check("rel_done_stay_lo", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; s_data = '0; s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_dbg_wen", 32'(dbg_wen), 32'd0);
    check("rst_dbg_addr", 32'(dbg_addr), 32'd0);
    check("rst_dbg_wdata", 32'(dbg_wdata), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_csum", 32'(csum), 32'd0);
    rst_n = 1'b1;
    check_release();

    // Four bytes back-to-back at ROM 0 start.
    exp_addr = 12'h000; exp_csum = 8'd0;
    do_start(12'h000, 13'd4);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t2_err", 32'(err), 32'd0);
    send_byte(8'hD4, 0); send_byte(8'hF0, 0); send_byte(8'h40, 0); send_byte(8'h00, 0);
    check("t2_s_ready_off", 32'(s_ready), 32'd0);
    wait_done("t2");
    check("t2_wen_count", 32'(n_wen), 32'd4);

    // ROM 0 -> ROM 1 crossing with stream gaps.
    exp_addr = 12'h0FE; exp_csum = 8'd0;
    do_start(12'h0FE, 13'd3);
    send_byte(8'hA5, 2); send_byte(8'h3C, 2); send_byte(8'h81, 2);
    wait_done("t3");
    check("t3_wen_count", 32'(n_wen), 32'd7);

    // Rejected starts.
    do_start(12'h1FF, 13'd2);
    check("t4_err_range", 32'(err), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_cpu_rst", 32'(cpu_rst), 32'd0);
    tick();
    check("t4_err_pulse", 32'(err), 32'd0);
    do_start(12'h000, 13'd0);
    check("t4_err_len0", 32'(err), 32'd1);
    do_start(12'h000, 13'h1001);
    check("t4_err_len_big", 32'(err), 32'd1);
    check("t4_busy2", 32'(busy), 32'd0);

    // Exactly reaching the top of populated ROM is accepted.
    exp_addr = 12'h1FE; exp_csum = 8'd0;
    do_start(12'h1FE, 13'd2);
    check("t5_err", 32'(err), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    wait_done("t5");
    check("t5_wen_count", 32'(n_wen), 32'd9);

    // Start during LOAD is ignored; reset mid-load.
    exp_addr = 12'h010; exp_csum = 8'd0;
    do_start(12'h010, 13'd4);
    send_byte(8'h5A, 0);
    do_start(12'h1FF, 13'd2);
    check("t6_ignored_err", 32'(err), 32'd0);
    check("t6_ignored_busy", 32'(busy), 32'd1);
    send_byte(8'h6B, 0);
    check("t6_wen_before_rst", 32'(dbg_wen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_wen", 32'(dbg_wen), 32'd0);
    check("t6_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t6_rst_busy", 32'(busy), 32'd1);
    check("t6_rst_s_ready", 32'(s_ready), 32'd0);
    check("t6_rst_csum", 32'(csum), 32'd0);
    sb_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    check_release();
    check("t6_wen_count", 32'(n_wen), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
